// File: rtl/division_control_unit.sv
// Sequences an external multi-cycle unsigned divider for DIV/DIVU/REM/REMU, with sign fix-up and divide-by-zero/overflow bypass.
// Optional feature: `DIVCTL_RESULT_REUSE_EN keeps the last divider result so a repeated operand pair skips the divider.
module division_control_unit (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        valid_i,
   output logic        ready_o,
   input  logic [1:0]  op_i,
   input  logic [31:0] operand1_i,
   input  logic [31:0] operand2_i,
   input  logic        flush_i,
   output logic        div_start_o,
   output logic [31:0] div_dividend_o,
   output logic [31:0] div_divisor_o,
   input  logic        div_done_i,
   input  logic [31:0] div_quotient_i,
   input  logic [31:0] div_remainder_i,
   output logic        div_abort_o,
   output logic [31:0] result_o,
   output logic        result_valid_o,
   input  logic        result_ready_i,
   output logic        busy_o
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ISSUE = 3'd1,
      S_WAIT  = 3'd2,
      S_FIX   = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t      r_state;
   state_t      w_next;

   logic        w_accept;
   logic        w_signed;
   logic        w_div_zero;
   logic        w_overflow;
   logic        w_hit;
   logic        w_direct;
   logic        w_capture;
   logic [31:0] w_mag1;
   logic [31:0] w_mag2;
   logic [31:0] w_ent_quo;
   logic [31:0] w_ent_rem;

   logic        r_rem_sel;
   logic        r_signed;
   logic        r_neg1;
   logic        r_neg2;
   logic        r_nocorr;
   logic [31:0] r_mag1;
   logic [31:0] r_mag2;
   logic [31:0] r_quo;
   logic [31:0] r_rem;
   logic [31:0] r_result;

   logic        w_neg_q;
   logic        w_neg_r;
   logic [31:0] w_fix_q;
   logic [31:0] w_fix_r;

   // op_i[0] selects unsigned, op_i[1] selects remainder
   assign w_signed   = ~op_i[0];
   assign w_accept   = valid_i & ready_o & ~flush_i;
   assign w_mag1     = (w_signed & operand1_i[31]) ? (~operand1_i + 32'd1) : operand1_i;
   assign w_mag2     = (w_signed & operand2_i[31]) ? (~operand2_i + 32'd1) : operand2_i;
   assign w_div_zero = (operand2_i == 32'd0);
   assign w_overflow = w_signed & (operand1_i == 32'h8000_0000) & (operand2_i == 32'hFFFF_FFFF);
   assign w_direct   = w_div_zero | w_overflow | w_hit;
   assign w_capture  = (r_state == S_WAIT) & div_done_i & ~flush_i;

`ifdef DIVCTL_RESULT_REUSE_EN
   logic        r_ent_vld;
   logic        r_ent_signed;
   logic [31:0] r_ent_op1;
   logic [31:0] r_ent_op2;
   logic [31:0] r_ent_quo;
   logic [31:0] r_ent_rem;
   logic [31:0] r_op1;
   logic [31:0] r_op2;

   // Special-case operands never reach the divider, so a hit is always a normal request
   assign w_hit     = r_ent_vld & (r_ent_op1 == operand1_i) & (r_ent_op2 == operand2_i)
                    & (r_ent_signed == w_signed);
   assign w_ent_quo = r_ent_quo;
   assign w_ent_rem = r_ent_rem;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_op1        <= 32'd0;
         r_op2        <= 32'd0;
         r_ent_vld    <= 1'b0;
         r_ent_signed <= 1'b0;
         r_ent_op1    <= 32'd0;
         r_ent_op2    <= 32'd0;
         r_ent_quo    <= 32'd0;
         r_ent_rem    <= 32'd0;
      end else begin
         if (w_accept) begin
            r_op1 <= operand1_i;
            r_op2 <= operand2_i;
         end
         if (flush_i) begin
            r_ent_vld <= 1'b0;
         end else if (w_capture) begin
            r_ent_vld    <= 1'b1;
            r_ent_signed <= r_signed;
            r_ent_op1    <= r_op1;
            r_ent_op2    <= r_op2;
            r_ent_quo    <= div_quotient_i;
            r_ent_rem    <= div_remainder_i;
         end
      end
   end
`else
   assign w_hit     = 1'b0;
   assign w_ent_quo = 32'd0;
   assign w_ent_rem = 32'd0;
`endif

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      if (flush_i) begin
         w_next = S_IDLE;
      end else begin
         unique case (r_state)
            S_IDLE:  if (w_accept) w_next = w_direct ? S_FIX : S_ISSUE;
            S_ISSUE: w_next = S_WAIT;
            S_WAIT:  if (div_done_i) w_next = S_FIX;
            S_FIX:   w_next = S_DONE;
            S_DONE:  if (result_ready_i) w_next = S_IDLE;
            default: w_next = S_IDLE;
         endcase
      end
   end

   always_comb begin
      ready_o        = 1'b0;
      div_start_o    = 1'b0;
      div_abort_o    = 1'b0;
      result_valid_o = 1'b0;
      busy_o         = 1'b1;
      unique case (r_state)
         S_IDLE: begin
            ready_o = rst_i;
            busy_o  = 1'b0;
         end
         S_ISSUE: begin
            div_start_o = ~flush_i;
            div_abort_o = flush_i;
         end
         S_WAIT:  div_abort_o    = flush_i;
         S_DONE:  result_valid_o = 1'b1;
         default: busy_o         = 1'b1;
      endcase
   end

   // Special cases load final-form raw values: the zero-divisor remainder already is the signed dividend
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_rem_sel <= 1'b0;
         r_signed  <= 1'b0;
         r_neg1    <= 1'b0;
         r_neg2    <= 1'b0;
         r_nocorr  <= 1'b0;
         r_mag1    <= 32'd0;
         r_mag2    <= 32'd0;
         r_quo     <= 32'd0;
         r_rem     <= 32'd0;
         r_result  <= 32'd0;
      end else begin
         if (w_accept) begin
            r_rem_sel <= op_i[1];
            r_signed  <= w_signed;
            r_neg1    <= w_signed & operand1_i[31];
            r_neg2    <= w_signed & operand2_i[31];
            r_nocorr  <= w_div_zero | w_overflow;
            r_mag1    <= w_mag1;
            r_mag2    <= w_mag2;
            if (w_div_zero) begin
               r_quo <= 32'hFFFF_FFFF;
               r_rem <= operand1_i;
            end else if (w_overflow) begin
               r_quo <= 32'h8000_0000;
               r_rem <= 32'd0;
            end else if (w_hit) begin
               r_quo <= w_ent_quo;
               r_rem <= w_ent_rem;
            end
         end else if (w_capture) begin
            r_quo <= div_quotient_i;
            r_rem <= div_remainder_i;
         end
         if ((r_state == S_FIX) && !flush_i) begin
            r_result <= r_rem_sel ? w_fix_r : w_fix_q;
         end
      end
   end

   assign w_neg_q = r_signed & ~r_nocorr & (r_neg1 ^ r_neg2);
   assign w_neg_r = r_signed & ~r_nocorr & r_neg1;
   assign w_fix_q = w_neg_q ? (~r_quo + 32'd1) : r_quo;
   assign w_fix_r = w_neg_r ? (~r_rem + 32'd1) : r_rem;

   assign div_dividend_o = r_mag1;
   assign div_divisor_o  = r_mag2;
   assign result_o       = r_result;

endmodule

// File: tb/tb_division_control_unit.sv
// Scoreboarded bench for division_control_unit: a behavioural divider responds to div_start_o,
// expected results come from plain signed/unsigned arithmetic and are checked when result_valid_o appears.
module tb_division_control_unit;

`ifdef DIVCTL_RESULT_REUSE_EN
   localparam bit REUSE = 1'b1;
`else
   localparam bit REUSE = 1'b0;
`endif

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b0;
   logic        valid_i = 1'b0;
   logic [1:0]  op_i = 2'd0;
   logic [31:0] operand1_i = 32'd0;
   logic [31:0] operand2_i = 32'd0;
   logic        flush_i = 1'b0;
   logic        div_done_i = 1'b0;
   logic [31:0] div_quotient_i = 32'd0;
   logic [31:0] div_remainder_i = 32'd0;
   logic        result_ready_i = 1'b0;
   logic        ready_o, div_start_o, div_abort_o, result_valid_o, busy_o;
   logic [31:0] div_dividend_o, div_divisor_o, result_o;

   division_control_unit dut (
      .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o), .op_i(op_i),
      .operand1_i(operand1_i), .operand2_i(operand2_i), .flush_i(flush_i),
      .div_start_o(div_start_o), .div_dividend_o(div_dividend_o), .div_divisor_o(div_divisor_o),
      .div_done_i(div_done_i), .div_quotient_i(div_quotient_i), .div_remainder_i(div_remainder_i),
      .div_abort_o(div_abort_o), .result_o(result_o), .result_valid_o(result_valid_o),
      .result_ready_i(result_ready_i), .busy_o(busy_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic [31:0] res;
      int          acc;
      bit          direct;
      int          starts;
   } exp_t;

   exp_t        exp_q[$];
   int          n_vec = 0;
   int          n_err = 0;
   int          cyc = 0;
   int          n_start = 0;
   int          n_start_exp = 0;
   int          last_start = 0;
   int          last_done = 0;
   int          div_lat = 4;
   int          hold_len = 0;
   bit          rand_bp = 1'b0;
   bit          spur_en = 1'b0;
   logic [31:0] exp_mag1 = 32'd0;
   logic [31:0] exp_mag2 = 32'd0;
   bit          ent_vld = 1'b0;
   bit          ent_s = 1'b0;
   logic [31:0] ent_a = 32'd0;
   logic [31:0] ent_b = 32'd0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Architectural result of the four operations, including the RISC-V style corner cases
   function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      logic [31:0] q, r;
      if (b == 32'd0) begin
         q = 32'hFFFF_FFFF;
         r = a;
      end else if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
         q = a;
         r = 32'd0;
      end else if (!op[0]) begin
         q = $signed(a) / $signed(b);
         r = $signed(a) % $signed(b);
      end else begin
         q = a / b;
         r = a % b;
      end
      return op[1] ? r : q;
   endfunction

   function automatic logic [31:0] mag(input bit sgn, input logic [31:0] v);
      return (sgn && $signed(v) < 0) ? 32'(-$signed(v)) : v;
   endfunction

   initial forever begin
      @(posedge clk_i);
      cyc++;
   end

   // Behavioural divider: done arrives div_lat cycles after start; optional stray done pulses elsewhere
   initial begin
      bit          pend;
      int          done_at;
      logic [31:0] pq, pr;
      pend = 1'b0;
      done_at = 0;
      pq = 32'd0;
      pr = 32'd0;
      forever begin
         @(posedge clk_i);
         #1;
         if (pend && cyc == done_at) begin
            div_done_i = 1'b1;
            div_quotient_i = pq;
            div_remainder_i = pr;
            pend = 1'b0;
            last_done = cyc;
         end else if (spur_en && !pend && $urandom_range(0, 7) == 0) begin
            div_done_i = 1'b1;
            div_quotient_i = $urandom;
            div_remainder_i = $urandom;
         end else begin
            div_done_i = 1'b0;
         end
         @(negedge clk_i);
         if (!rst_i) pend = 1'b0;
         if (div_start_o) begin
            n_start++;
            last_start = cyc;
            pend = 1'b1;
            done_at = cyc + div_lat;
            chk("dividend magnitude", div_dividend_o, exp_mag1);
            chk("divisor magnitude", div_divisor_o, exp_mag2);
            pq = (div_divisor_o == 0) ? 32'hFFFF_FFFF : div_dividend_o / div_divisor_o;
            pr = (div_divisor_o == 0) ? div_dividend_o : div_dividend_o % div_divisor_o;
         end
      end
   end

   initial begin
      int vcyc;
      vcyc = 0;
      forever begin
         @(posedge clk_i);
         #1;
         if (result_valid_o) vcyc++;
         else vcyc = 0;
         result_ready_i = (vcyc > hold_len) && (!rand_bp || $urandom_range(0, 2) != 0);
      end
   end

   // Monitor: pops the scoreboard on each result handshake
   initial begin
      bit   seen;
      exp_t e;
      seen = 1'b0;
      forever begin
         @(negedge clk_i);
         if (result_valid_o) begin
            if (exp_q.size() == 0) begin
               chk("unexpected result_valid", 32'(result_valid_o), 32'd0);
            end else begin
               e = exp_q[0];
               if (!seen) begin
                  seen = 1'b1;
                  chk("result", result_o, e.res);
                  chk("divider start count", 32'(n_start), 32'(e.starts));
                  if (e.direct) begin
                     chk("direct latency", 32'(cyc - e.acc), 32'd2);
                  end else begin
                     chk("start cycle after accept", 32'(last_start - e.acc), 32'd1);
                     chk("done to valid", 32'(cyc - last_done), 32'd2);
                  end
               end else begin
                  chk("held result", result_o, e.res);
               end
               chk("ready_o while result pending", 32'(ready_o), 32'd0);
               if (result_ready_i) begin
                  void'(exp_q.pop_front());
                  seen = 1'b0;
               end
            end
         end
      end
   end

   // kill: 0 normal, 1 flush in ISSUE, 2 flush in WAIT, 3 reset in WAIT
   task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int lat, input int kill);
      int budget;
      bit special, hit, direct;
      budget = 0;
      while (!ready_o && budget < 300) begin
         @(posedge clk_i);
         #1;
         budget++;
      end
      if (!ready_o) begin
         chk("ready_o timeout", 32'(ready_o), 32'd1);
         return;
      end
      special = (b == 32'd0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
      hit = REUSE && !special && ent_vld && ent_a == a && ent_b == b && ent_s == !op[0];
      direct = special || hit;
      div_lat = lat;
      exp_mag1 = mag(!op[0], a);
      exp_mag2 = mag(!op[0], b);
      valid_i = 1'b1;
      op_i = op;
      operand1_i = a;
      operand2_i = b;
      if (!direct) begin
         if (kill != 1) n_start_exp++;
         ent_vld = 1'b1;
         ent_a = a;
         ent_b = b;
         ent_s = !op[0];
      end
      if (kill == 0) exp_q.push_back('{ref_div(op, a, b), cyc, direct, n_start_exp});
      @(posedge clk_i);
      #1;
      valid_i = 1'b0;
      operand1_i = $urandom;
      operand2_i = $urandom;
      if (kill != 0) begin
         if (kill >= 2) repeat (2) begin
            @(posedge clk_i);
            #1;
         end
         if (kill == 3) rst_i = 1'b0;
         else flush_i = 1'b1;
         #1;
         chk("abort on kill", 32'(div_abort_o), (kill == 3) ? 32'd0 : 32'd1);
         if (kill == 3) begin
            chk("busy in reset", 32'(busy_o), 32'd0);
            chk("ready in reset", 32'(ready_o), 32'd0);
         end
         @(posedge clk_i);
         #1;
         flush_i = 1'b0;
         rst_i = 1'b1;
         ent_vld = 1'b0;
         #1;
         chk("busy after kill", 32'(busy_o), 32'd0);
         chk("abort single cycle", 32'(div_abort_o), 32'd0);
         chk("ready after kill", 32'(ready_o), 32'd1);
         repeat (12) @(posedge clk_i);
         #1;
      end
   endtask

   initial begin
      logic [31:0] pa, pb, a, b;
      logic [1:0]  op;
      int          budget;
      pa = 32'd0;
      pb = 32'd1;
      repeat (2) @(posedge clk_i);
      #1;
      chk("reset ready_o", 32'(ready_o), 32'd0);
      chk("reset busy_o", 32'(busy_o), 32'd0);
      chk("reset result_valid_o", 32'(result_valid_o), 32'd0);
      chk("reset result_o", result_o, 32'd0);
      chk("reset div_start_o", 32'(div_start_o), 32'd0);
      chk("reset div_abort_o", 32'(div_abort_o), 32'd0);
      chk("reset dividend", div_dividend_o, 32'd0);
      rst_i = 1'b1;
      #1;
      chk("ready after release", 32'(ready_o), 32'd1);
      @(posedge clk_i);
      #1;

      issue(2'd0, 32'hFFFF_FFF9, 32'd2, 4, 0);          // DIV -7/2
      issue(2'd2, 32'hFFFF_FFF9, 32'd2, 3, 0);          // REM -7/2
      issue(2'd3, 32'd7, 32'd0, 3, 0);                  // REMU 7/0
      issue(2'd0, 32'h8000_0000, 32'hFFFF_FFFF, 3, 0);  // DIV overflow
      issue(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 3, 0);  // REM overflow
      issue(2'd2, 32'hFFFF_FFF9, 32'd0, 3, 0);          // REM -7/0
      issue(2'd1, 32'd1000, 32'd3, 8, 2);               // flush in WAIT, late done
      issue(2'd0, 32'd12345, 32'd77, 4, 1);             // flush in ISSUE

      valid_i = 1'b1;
      flush_i = 1'b1;
      op_i = 2'd1;
      operand1_i = 32'd50;
      operand2_i = 32'd5;
      ent_vld = 1'b0;
      @(posedge clk_i);
      #1;
      valid_i = 1'b0;
      flush_i = 1'b0;
      chk("request with flush ignored", 32'(busy_o), 32'd0);

      hold_len = 5;
      issue(2'd1, 32'd99, 32'd10, 2, 0);
      budget = 0;
      while (exp_q.size() != 0 && budget < 100) begin
         @(posedge clk_i);
         #1;
         budget++;
      end
      hold_len = 0;

      issue(2'd0, 32'd100, 32'd7, 3, 0);
      issue(2'd2, 32'd100, 32'd7, 3, 0);
      issue(2'd1, 32'd555, 32'd5, 9, 3);                // reset in WAIT
      issue(2'd2, 32'd100, 32'd7, 2, 0);

      spur_en = 1'b1;
      rand_bp = 1'b1;
      for (int i = 0; i < 300; i++) begin
         op = 2'($urandom_range(0, 3));
         if (i > 0 && $urandom_range(0, 3) == 0) begin
            a = pa;
            b = pb;
         end else begin
            case ($urandom_range(0, 5))
               0:       b = 32'd0;
               1:       b = 32'hFFFF_FFFF;
               2:       b = 32'($urandom_range(1, 20));
               3:       b = -32'($urandom_range(1, 20));
               default: b = $urandom;
            endcase
            case ($urandom_range(0, 4))
               0:       a = 32'h8000_0000;
               1:       a = 32'($urandom_range(0, 200));
               default: a = $urandom;
            endcase
         end
         pa = a;
         pb = b;
         issue(op, a, b, $urandom_range(1, 6), 0);
      end

      budget = 0;
      while (exp_q.size() != 0 && budget < 500) begin
         @(posedge clk_i);
         #1;
         budget++;
      end
      chk("scoreboard drained", 32'(exp_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
